// File: rtl/exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// exception_unit_pkg
// Shared definitions for the exception sequencer and the multi-cycle datapath
// that consumes its select outputs:
//   - FSM state encoding
//   - exception cause codes (also used directly as the vector select)
//   - handler vector addresses
//   - mux-select encodings for iord / pc_src / alu_srca / alu_srcb / alu_op
// Encoding 0 of every select is the neutral value the datapath sees whenever
// the exception unit is not steering it.
// -----------------------------------------------------------------------------
package exception_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_EPC = 3'd1,
    ST_VEC_ADDR = 3'd2,
    ST_VEC_WAIT = 3'd3,
    ST_LOAD_PC  = 3'd4,
    ST_DONE     = 3'd5
  } excp_state_t;

  // Cause code doubles as the vector select: 00->253, 01->254, 10->255.
  typedef enum logic [1:0] {
    CAUSE_OPCODE   = 2'b00,
    CAUSE_OVERFLOW = 2'b01,
    CAUSE_DIV_ZERO = 2'b10
  } excp_cause_t;

  localparam logic [7:0] VEC_ADDR_OPCODE   = 8'd253;
  localparam logic [7:0] VEC_ADDR_OVERFLOW = 8'd254;
  localparam logic [7:0] VEC_ADDR_DIV_ZERO = 8'd255;

  // Memory address source.
  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_ALUOUT = 3'd1;
  localparam logic [2:0] IORD_VECTOR = 3'd4;

  // PC source.
  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
  localparam logic [1:0] PC_SRC_HANDLER = 2'd3;

  // ALU operand A source.
  localparam logic [1:0] ALU_SRCA_NONE = 2'd0;
  localparam logic [1:0] ALU_SRCA_PC   = 2'd1;
  localparam logic [1:0] ALU_SRCA_REG  = 2'd2;

  // ALU operand B source.
  localparam logic [1:0] ALU_SRCB_NONE   = 2'd0;
  localparam logic [1:0] ALU_SRCB_CONST4 = 2'd1;
  localparam logic [1:0] ALU_SRCB_REG    = 2'd2;
  localparam logic [1:0] ALU_SRCB_IMM    = 2'd3;

  // ALU operation.
  localparam logic [2:0] ALU_OP_NOP = 3'd0;
  localparam logic [2:0] ALU_OP_ADD = 3'd1;
  localparam logic [2:0] ALU_OP_SUB = 3'd2;

  // Fixed priority: opcode_invalid > overflow > div_zero.
  function automatic excp_cause_t pick_cause(input logic opcode_invalid,
                                             input logic overflow,
                                             input logic div_zero);
    if (opcode_invalid) return CAUSE_OPCODE;
    if (overflow)       return CAUSE_OVERFLOW;
    if (div_zero)       return CAUSE_DIV_ZERO;
    return CAUSE_OPCODE;
  endfunction

  // Handler vector address for a cause (for datapath address muxing).
  function automatic logic [7:0] vector_addr(input excp_cause_t cause);
    case (cause)
      CAUSE_OVERFLOW: return VEC_ADDR_OVERFLOW;
      CAUSE_DIV_ZERO: return VEC_ADDR_DIV_ZERO;
      default:        return VEC_ADDR_OPCODE;
    endcase
  endfunction

endpackage

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Sequencer that takes an exception for a multi-cycle CPU: saves PC-4 into
// EPC, reads the handler byte from the cause-dependent vector address, waits
// MEM_WAIT cycles for memory, loads PC with the zero-extended byte and
// signals completion. Main control holds while busy is high.
//
// Parameter
//   MEM_WAIT       memory read wait cycles (legal 1..7)
// Ports
//   clk            clock, all state on rising edge
//   reset          synchronous active-low reset
//   check_en       flags below are valid this cycle
//   opcode_invalid / overflow / div_zero   exception flags
//   mem_byte       low byte of memory read data (handler address)
//   busy           sequence in progress
//   excp_taken     1-cycle pulse on acceptance
//   done           1-cycle pulse when PC holds the handler address
//   excp_ctrl      vector select while addressing the vector
//   excp_cause     sticky cause of the last accepted exception
//   epc_write      EPC load enable
//   alu_srca_sel / alu_srcb_sel / alu_op   ALU setup for EPC = PC - 4
//   iord_sel       memory address source
//   pc_src_sel / pc_write   PC source and load enable
//   handler_addr   {24'b0, mem_byte} during the PC load cycle, else 0
// -----------------------------------------------------------------------------
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        check_en,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [7:0]  mem_byte,
  output logic        busy,
  output logic        excp_taken,
  output logic        done,
  output logic [1:0]  excp_ctrl,
  output logic [1:0]  excp_cause,
  output logic        epc_write,
  output logic [1:0]  alu_srca_sel,
  output logic [1:0]  alu_srcb_sel,
  output logic [2:0]  alu_op,
  output logic [2:0]  iord_sel,
  output logic [1:0]  pc_src_sel,
  output logic        pc_write,
  output logic [31:0] handler_addr
);

  // Counter starts at MEM_WAIT-1 so that VEC_WAIT lasts exactly MEM_WAIT cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  excp_state_t r_state;
  excp_state_t w_state_next;
  logic [2:0]  r_wait_cnt;
  logic [2:0]  w_wait_cnt_next;
  excp_cause_t r_cause;
  excp_cause_t w_cause_next;
  logic        w_any_flag;

  assign w_any_flag = opcode_invalid | overflow | div_zero;
  assign excp_cause = r_cause;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
      r_cause    <= CAUSE_OPCODE;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_cause    <= w_cause_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_cause_next    = r_cause;
    busy            = 1'b0;
    excp_taken      = 1'b0;
    done            = 1'b0;
    excp_ctrl       = 2'b00;
    epc_write       = 1'b0;
    alu_srca_sel    = ALU_SRCA_NONE;
    alu_srcb_sel    = ALU_SRCB_NONE;
    alu_op          = ALU_OP_NOP;
    iord_sel        = IORD_PC;
    pc_src_sel      = PC_SRC_ALU;
    pc_write        = 1'b0;
    handler_addr    = 32'd0;

    case (r_state)
      ST_IDLE: begin
        // excp_taken is combinational on the strobe; it is masked while reset
        // is held so that no output rises during reset.
        if (reset && check_en && w_any_flag) begin
          excp_taken   = 1'b1;
          w_cause_next = pick_cause(opcode_invalid, overflow, div_zero);
          w_state_next = ST_SAVE_EPC;
        end
      end

      ST_SAVE_EPC: begin
        busy         = 1'b1;
        alu_srca_sel = ALU_SRCA_PC;
        alu_srcb_sel = ALU_SRCB_CONST4;
        alu_op       = ALU_OP_SUB;
        epc_write    = 1'b1;
        w_state_next = ST_VEC_ADDR;
      end

      ST_VEC_ADDR: begin
        busy            = 1'b1;
        iord_sel        = IORD_VECTOR;
        excp_ctrl       = r_cause;
        w_wait_cnt_next = WAIT_LOAD;
        w_state_next    = ST_VEC_WAIT;
      end

      ST_VEC_WAIT: begin
        busy      = 1'b1;
        iord_sel  = IORD_VECTOR;
        excp_ctrl = r_cause;
        if (r_wait_cnt == 3'd0) begin
          w_state_next = ST_LOAD_PC;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 3'd1;
        end
      end

      ST_LOAD_PC: begin
        busy         = 1'b1;
        pc_src_sel   = PC_SRC_HANDLER;
        pc_write     = 1'b1;
        handler_addr = {24'd0, mem_byte};
        w_state_next = ST_DONE;
      end

      ST_DONE: begin
        // Strobes here are dropped; the next acceptable one is in IDLE.
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_exception_unit
// Two instances: dut A with MEM_WAIT=2, dut B with MEM_WAIT=5. Flags and
// mem_byte are shared, each dut has its own check_en. Every accepted exception
// pushes an expected record (cause, handler byte, excp_taken->done latency)
// into that dut's queue; a monitor pops it on done.
// -----------------------------------------------------------------------------
module tb_exception_unit;
  import exception_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       check_en_a, check_en_b;
  logic       opcode_invalid, overflow, div_zero;
  logic [7:0] mem_byte;

  logic        busy_a, excp_taken_a, done_a, epc_write_a, pc_write_a;
  logic [1:0]  excp_ctrl_a, excp_cause_a, alu_srca_sel_a, alu_srcb_sel_a, pc_src_sel_a;
  logic [2:0]  alu_op_a, iord_sel_a;
  logic [31:0] handler_addr_a;

  logic        busy_b, excp_taken_b, done_b, epc_write_b, pc_write_b;
  logic [1:0]  excp_ctrl_b, excp_cause_b, alu_srca_sel_b, alu_srcb_sel_b, pc_src_sel_b;
  logic [2:0]  alu_op_b, iord_sel_b;
  logic [31:0] handler_addr_b;

  exception_unit #(.MEM_WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .check_en(check_en_a),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .mem_byte(mem_byte), .busy(busy_a), .excp_taken(excp_taken_a), .done(done_a),
    .excp_ctrl(excp_ctrl_a), .excp_cause(excp_cause_a), .epc_write(epc_write_a),
    .alu_srca_sel(alu_srca_sel_a), .alu_srcb_sel(alu_srcb_sel_a), .alu_op(alu_op_a),
    .iord_sel(iord_sel_a), .pc_src_sel(pc_src_sel_a), .pc_write(pc_write_a),
    .handler_addr(handler_addr_a)
  );

  exception_unit #(.MEM_WAIT(5)) dut_b (
    .clk(clk), .reset(reset), .check_en(check_en_b),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .mem_byte(mem_byte), .busy(busy_b), .excp_taken(excp_taken_b), .done(done_b),
    .excp_ctrl(excp_ctrl_b), .excp_cause(excp_cause_b), .epc_write(epc_write_b),
    .alu_srca_sel(alu_srca_sel_b), .alu_srcb_sel(alu_srcb_sel_b), .alu_op(alu_op_b),
    .iord_sel(iord_sel_b), .pc_src_sel(pc_src_sel_b), .pc_write(pc_write_b),
    .handler_addr(handler_addr_b)
  );

  logic [52:0] all_a, all_b;
  assign all_a = {busy_a, excp_taken_a, done_a, excp_ctrl_a, excp_cause_a, epc_write_a,
                  alu_srca_sel_a, alu_srcb_sel_a, alu_op_a, iord_sel_a, pc_src_sel_a,
                  pc_write_a, handler_addr_a};
  assign all_b = {busy_b, excp_taken_b, done_b, excp_ctrl_b, excp_cause_b, epc_write_b,
                  alu_srca_sel_b, alu_srcb_sel_b, alu_op_b, iord_sel_b, pc_src_sel_b,
                  pc_write_b, handler_addr_b};

  typedef struct {
    logic [1:0] cause;
    logic [7:0] handler;
    int         latency;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_taken_a = 0;
  int   t_taken_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: compare handler load and completion against queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (excp_taken_a === 1'b1) t_taken_a = cyc;
      if (pc_write_a === 1'b1) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL pc_write_a: got pc_write=1 with no exception pending, want 0");
        end else if (handler_addr_a !== {24'd0, q_a[0].handler} || pc_src_sel_a !== PC_SRC_HANDLER) begin
          n_fail++;
          $display("FAIL handler_a: got addr=%h src=%0d, want addr=%h src=%0d",
                   handler_addr_a, pc_src_sel_a, {24'd0, q_a[0].handler}, PC_SRC_HANDLER);
        end else begin
          $display("dut_a load pc  addr=%h", handler_addr_a);
        end
      end
      if (done_a === 1'b1) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL done_a: got done=1 with no exception pending, want 0");
        end else begin
          e_a = q_a.pop_front();
          if ((cyc - t_taken_a) != e_a.latency || excp_cause_a !== e_a.cause) begin
            n_fail++;
            $display("FAIL done_a: got latency=%0d cause=%b, want latency=%0d cause=%b",
                     cyc - t_taken_a, excp_cause_a, e_a.latency, e_a.cause);
          end else begin
            $display("dut_a done     latency=%0d cause=%b", cyc - t_taken_a, excp_cause_a);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (excp_taken_b === 1'b1) t_taken_b = cyc;
      if (pc_write_b === 1'b1) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL pc_write_b: got pc_write=1 with no exception pending, want 0");
        end else if (handler_addr_b !== {24'd0, q_b[0].handler} || pc_src_sel_b !== PC_SRC_HANDLER) begin
          n_fail++;
          $display("FAIL handler_b: got addr=%h src=%0d, want addr=%h src=%0d",
                   handler_addr_b, pc_src_sel_b, {24'd0, q_b[0].handler}, PC_SRC_HANDLER);
        end else begin
          $display("dut_b load pc  addr=%h", handler_addr_b);
        end
      end
      if (done_b === 1'b1) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL done_b: got done=1 with no exception pending, want 0");
        end else begin
          e_b = q_b.pop_front();
          if ((cyc - t_taken_b) != e_b.latency || excp_cause_b !== e_b.cause) begin
            n_fail++;
            $display("FAIL done_b: got latency=%0d cause=%b, want latency=%0d cause=%b",
                     cyc - t_taken_b, excp_cause_b, e_b.latency, e_b.cause);
          end else begin
            $display("dut_b done     latency=%0d cause=%b", cyc - t_taken_b, excp_cause_b);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until both scoreboards are empty and both duts idle (bounded).
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (q_a.size() == 0 && q_b.size() == 0 && busy_a === 1'b0 && busy_b === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; check_en_a = 1'b0; check_en_b = 1'b0;
    opcode_invalid = 1'b0; overflow = 1'b0; div_zero = 1'b0; mem_byte = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (all_a !== 53'd0) begin
      n_fail++; $display("FAIL reset_a: got outputs=%h, want 0", all_a);
    end
    n_cmp++;
    if (all_b !== 53'd0) begin
      n_fail++; $display("FAIL reset_b: got outputs=%h, want 0", all_b);
    end
    $display("reset          outputs_a=%h outputs_b=%h", all_a, all_b);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_overflow();
    bit ok;
    tick();
    overflow = 1'b1; check_en_a = 1'b1; mem_byte = 8'h40;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL ovf_taken: got taken=%b busy=%b, want taken=1 busy=0", excp_taken_a, busy_a);
    end
    q_a.push_back('{2'b01, 8'h40, 6});
    $display("ovf accept     taken=%b", excp_taken_a);
    tick();
    check_en_a = 1'b0; overflow = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({epc_write_a, alu_srca_sel_a, alu_srcb_sel_a, alu_op_a, busy_a, excp_cause_a, pc_write_a} !==
        {1'b1, ALU_SRCA_PC, ALU_SRCB_CONST4, ALU_OP_SUB, 1'b1, 2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_save_epc: got epc_we=%b a=%0d b=%0d op=%0d busy=%b cause=%b, want 1 %0d %0d %0d 1 01",
               epc_write_a, alu_srca_sel_a, alu_srcb_sel_a, alu_op_a, busy_a, excp_cause_a,
               ALU_SRCA_PC, ALU_SRCB_CONST4, ALU_OP_SUB);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (excp_ctrl_a !== 2'b01 || iord_sel_a !== IORD_VECTOR || epc_write_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_vec_addr: got ctrl=%b iord=%0d epc_we=%b, want ctrl=01 iord=%0d epc_we=0",
               excp_ctrl_a, iord_sel_a, epc_write_a, IORD_VECTOR);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ovf_drain: got timeout, want idle"); end
  endtask

  task automatic test_priority();
    bit ok;
    opcode_invalid = 1'b1; overflow = 1'b1; div_zero = 1'b1; check_en_a = 1'b1; mem_byte = 8'h9C;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b1) begin
      n_fail++; $display("FAIL prio_taken: got %b, want 1", excp_taken_a);
    end
    q_a.push_back('{2'b00, 8'h9C, 6});
    tick();
    opcode_invalid = 1'b0; overflow = 1'b0; div_zero = 1'b0; check_en_a = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (excp_ctrl_a !== 2'b00 || excp_cause_a !== 2'b00 || iord_sel_a !== IORD_VECTOR) begin
      n_fail++;
      $display("FAIL prio_vector: got ctrl=%b cause=%b iord=%0d, want ctrl=00 cause=00 iord=%0d",
               excp_ctrl_a, excp_cause_a, iord_sel_a, IORD_VECTOR);
    end
    $display("priority       ctrl=%b cause=%b", excp_ctrl_a, excp_cause_a);
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL prio_drain: got timeout, want idle"); end
  endtask

  task automatic test_no_strobe();
    overflow = 1'b1; check_en_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (excp_taken_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++; $display("FAIL nostrobe_%0d: got taken=%b busy=%b, want 0 0", k, excp_taken_a, busy_a);
      end
      tick();
    end
    overflow = 1'b0; check_en_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL noflags: got taken=%b busy=%b, want 0 0", excp_taken_a, busy_a);
    end
    $display("no strobe      taken=%b busy=%b", excp_taken_a, busy_a);
    tick();
    check_en_a = 1'b0;
  endtask

  task automatic test_ignore_busy();
    bit ok;
    div_zero = 1'b1; check_en_a = 1'b1; mem_byte = 8'h5A;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b1) begin
      n_fail++; $display("FAIL dz_taken: got %b, want 1", excp_taken_a);
    end
    q_a.push_back('{2'b10, 8'h5A, 6});
    tick();
    div_zero = 1'b0; check_en_a = 1'b0;
    tick();
    tick();
    check_en_a = 1'b1; overflow = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b0 || busy_a !== 1'b1 || iord_sel_a !== IORD_VECTOR) begin
      n_fail++;
      $display("FAIL busy_ignore: got taken=%b busy=%b iord=%0d, want taken=0 busy=1 iord=%0d",
               excp_taken_a, busy_a, iord_sel_a, IORD_VECTOR);
    end
    tick();
    check_en_a = 1'b0; overflow = 1'b0;
    drain(ok);
    n_cmp++;
    if (!ok || excp_cause_a !== 2'b10) begin
      n_fail++; $display("FAIL busy_cause: got ok=%b cause=%b, want ok=1 cause=10", ok, excp_cause_a);
    end
    $display("busy ignore    cause=%b", excp_cause_a);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic want;
    overflow = 1'b1; check_en_a = 1'b1; mem_byte = 8'h77;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      want = (k == 0 || k == 7);
      n_cmp++;
      if (excp_taken_a !== want || done_a !== (k == 6)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got taken=%b done=%b, want taken=%b done=%b",
                 k, excp_taken_a, done_a, want, (k == 6));
      end
      if (want) q_a.push_back('{2'b01, 8'h77, 6});
    end
    tick();
    check_en_a = 1'b0; overflow = 1'b0;
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got timeout, want idle"); end
    $display("back to back   second accept on first IDLE cycle");
  endtask

  task automatic test_mem_wait5();
    bit ok;
    int vec_cycles;
    vec_cycles = 0;
    overflow = 1'b1; check_en_b = 1'b1; mem_byte = 8'hC3;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_b !== 1'b1) begin
      n_fail++; $display("FAIL mw5_taken: got %b, want 1", excp_taken_b);
    end
    q_b.push_back('{2'b01, 8'hC3, 9});
    tick();
    overflow = 1'b0; check_en_b = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (iord_sel_b === IORD_VECTOR && excp_ctrl_b === 2'b01) vec_cycles++;
      if (done_b === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (vec_cycles != 6) begin
      n_fail++; $display("FAIL mw5_vector_cycles: got %0d, want 6", vec_cycles);
    end
    $display("mem_wait 5     vector cycles=%0d", vec_cycles);
    drain(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL mw5_drain: got timeout, want idle"); end
  endtask

  task automatic test_reset_mid();
    div_zero = 1'b1; check_en_a = 1'b1; mem_byte = 8'h11;
    @(negedge clk);
    n_cmp++;
    if (excp_taken_a !== 1'b1) begin
      n_fail++; $display("FAIL rmid_taken: got %b, want 1", excp_taken_a);
    end
    q_a.push_back('{2'b10, 8'h11, 6});
    tick();
    div_zero = 1'b0; check_en_a = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    q_a.delete();
    @(negedge clk);
    n_cmp++;
    if (all_a !== 53'd0) begin
      n_fail++; $display("FAIL rmid_outputs: got %h, want 0", all_a);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (epc_write_a !== 1'b0 || pc_write_a !== 1'b0 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_release%0d: got epc_we=%b pc_we=%b busy=%b, want 0 0 0",
                 k, epc_write_a, pc_write_a, busy_a);
      end
      tick();
    end
    $display("reset mid      outputs cleared, cause=%b", excp_cause_a);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_no_strobe();
    test_ignore_busy();
    test_back_to_back();
    test_mem_wait5();
    test_reset_mid();
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
